// File: rtl/sr_button_ctrl.sv
// sr_button_ctrl: three raw buttons, each synchronized and debounced, driving an
// IDLE/RUN/HALT controller. Optional macro SR_TOGGLE_MODE_EN: start toggles RUN/HALT, stop ignored.
module sr_button_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_clear,
  output logic start,
  output logic stop,
  output logic clr,
  output logic running
);

  localparam int NBTN      = 3;
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_CLEAR = 2;
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  logic [NBTN-1:0]  w_raw;
  logic [NBTN-1:0]  r_sync1;
  logic [NBTN-1:0]  r_sync2;
  logic [NBTN-1:0]  r_level;
  logic [NBTN-1:0]  r_levelDly;
  logic [NBTN-1:0]  w_press;
  logic [DEB_W-1:0] r_cnt [NBTN];

  logic   w_evStart;
  logic   w_evStop;
  logic   w_evClear;
  state_t r_state;
  state_t w_stateNext;
  logic   w_startNext;
  logic   w_stopNext;
  logic   w_clrNext;
  logic   r_start;
  logic   r_stop;
  logic   r_clr;
  logic   r_running;

  assign w_raw = {btn_clear, btn_stop, btn_start};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level flips only after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_level[i] <= ~r_level[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_levelDly <= '0;
    end else begin
      r_levelDly <= r_level;
    end
  end

  assign w_press   = r_level & ~r_levelDly;
  assign w_evStart = w_press[BTN_START];
  assign w_evClear = w_press[BTN_CLEAR];
`ifdef SR_TOGGLE_MODE_EN
  assign w_evStop  = 1'b0;
`else
  assign w_evStop  = w_press[BTN_STOP];
`endif

  // Each state honours only its own events, so the stop > start > clear order
  // falls out of the if/else chain within each state.
  always_comb begin
    w_stateNext = r_state;
    w_startNext = 1'b0;
    w_stopNext  = 1'b0;
    w_clrNext   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_evStart) begin
          w_stateNext = RUN;
          w_startNext = 1'b1;
        end
      end
      RUN: begin
`ifdef SR_TOGGLE_MODE_EN
        if (w_evStart) begin
`else
        if (w_evStop) begin
`endif
          w_stateNext = HALT;
          w_stopNext  = 1'b1;
        end
      end
      HALT: begin
        if (w_evStart) begin
          w_stateNext = RUN;
          w_startNext = 1'b1;
        end else if (w_evClear) begin
          w_stateNext = IDLE;
          w_clrNext   = 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_start   <= w_startNext;
      r_stop    <= w_stopNext;
      r_clr     <= w_clrNext;
      r_running <= (w_stateNext == RUN);
    end
  end

  assign start   = r_start;
  assign stop    = r_stop;
  assign clr     = r_clr;
  assign running = r_running;

endmodule

// File: doc/sr_button_ctrl.md
SR_BUTTON_CTRL -- requirements
Module: sr_button_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, number of consecutive stable synchronized samples needed to accept a button level change (legal range 2..65535).
REQ-002 SHALL have parameter DEB_W, default 16, debounce counter width; DEB_W SHALL be >= clog2(DEB_CYCLES).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 btn_start  in  1  raw asynchronous start button, active-high.
REQ-006 btn_stop  in  1  raw asynchronous stop button, active-high.
REQ-007 btn_clear  in  1  raw asynchronous clear button, active-high.
REQ-008 start  out  1  single-cycle start command to the downstream counter.
REQ-009 stop  out  1  single-cycle stop command to the downstream counter.
REQ-010 clr  out  1  single-cycle clear command to the downstream counter.
REQ-011 running  out  1  high while the FSM is in RUN.

Function
REQ-012 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-013 Each button SHALL have a debounced level register and a DEB_W-bit counter: sample != debounced level increments the counter; sample == debounced level clears it to 0.
REQ-014 The debounced level SHALL toggle, and the counter SHALL clear, on the edge at which the counter reaches DEB_CYCLES-1 while the sample still differs.
REQ-015 A press event SHALL be a 0->1 transition of a debounced level; releases SHALL generate no event.
REQ-016 FSM states: IDLE, RUN, HALT.
REQ-017 IDLE: start event -> RUN and pulse start; stop and clear events ignored.
REQ-018 RUN: stop event -> HALT and pulse stop; start and clear events ignored.
REQ-019 HALT: start event -> RUN and pulse start; clear event -> IDLE and pulse clr; stop event ignored.
REQ-020 Events arriving in the same cycle SHALL be prioritized stop > start > clear; the rest are discarded, not queued.
REQ-021 start, stop, clr SHALL be registered, high for exactly one cycle per accepted event, and mutually exclusive.
REQ-022 A raw press held stable from before edge 1 SHALL produce its output pulse high in the cycle after edge DEB_CYCLES+3.
REQ-023 A pulse shorter than DEB_CYCLES synchronized samples SHALL produce no event.
REQ-024 running SHALL be a registered decode of state == RUN, changing on the same edge as the start or stop pulse.

Reset
REQ-025 While reset is low: state = IDLE; start, stop, clr, running = 0; synchronizers, debounced levels, and counters = 0.
REQ-026 Reset asserted mid-debounce SHALL discard the pending change; after release, a button already held SHALL be re-qualified from zero and SHALL generate a fresh event.
REQ-027 Reset deassertion SHALL cause no output pulse on the first edge.

Configuration
REQ-028 Macro SR_TOGGLE_MODE_EN: when defined, a start event in RUN SHALL act as a stop event (-> HALT, pulse stop), and btn_stop SHALL be ignored; when undefined, REQ-017..019 apply unchanged.
REQ-029 Port list SHALL be identical with and without SR_TOGGLE_MODE_EN.

Verification (DEB_CYCLES=4)
REQ-030 Reset released, btn_start high from edge 1 for 12 cycles -> start high only in the cycle after edge 7, running=1 from edge 7.
REQ-031 In RUN, btn_stop high for 3 cycles then low -> no stop pulse, running stays 1.
REQ-032 In RUN, btn_stop and btn_start both rise on the same cycle and hold -> one stop pulse only, state HALT, running=0.
REQ-033 In HALT, btn_clear held 8 cycles -> clr one cycle, state IDLE; a later btn_stop hold -> no output.
REQ-034 btn_start held, reset pulsed low at edge 5 and released -> no pulse before reset; start pulse 7 edges after release.
REQ-035 SR_TOGGLE_MODE_EN defined: two separate btn_start holds -> start pulse then stop pulse, final state HALT; btn_stop hold -> no output.
